// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state, owner encoding and default widths for the memory port arbiter
package mem_arb_pkg;
    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int MEM_DEPTH_DEF    = 8192;
    localparam int STARVE_LIMIT_DEF = 4;
    typedef enum logic [1:0] {ARB_IDLE, ARB_LS_RUN, ARB_FORCE_IF} arb_state_t;
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b10;
    localparam logic [1:0] OWN_LS   = 2'b01;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, load/store port and RAM bus of the arbiter
//   master: requesters and RAM (drive requests and ram_dout)
//   slave:  arbiter (drives grants, read returns and RAM controls)
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_WIDTH-1:0] ls_rdata;
    logic                  ls_err;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_rw;
    logic [DATA_WIDTH-1:0] ram_dout;
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_dout,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               ram_a, ram_din, ram_rw
    );
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_dout,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               ram_a, ram_din, ram_rw
    );
endinterface

// File: rtl/mem_port_arbiter_fairness.sv
// mem_arb_fairness: counts consecutive LS wins over a waiting fetch and forces IF at the limit
//   in:  clk, rst (async high), if_req, if_gnt, ls_gnt
//   out: force_if (registered, high while in ARB_FORCE_IF)
module mem_arb_fairness
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    input  logic ls_gnt,
    output logic force_if
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    arb_state_t state;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;
    assign cnt_inc = cnt + 4'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            cnt      <= '0;
            force_if <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: if (ls_gnt && if_req) begin
                    cnt      <= 4'd1;
                    state    <= (LIM == 4'd1) ? ARB_FORCE_IF : ARB_LS_RUN;
                    force_if <= LIM == 4'd1;
                end
                ARB_LS_RUN: if (ls_gnt && if_req) begin
                    cnt      <= cnt_inc;
                    state    <= (cnt_inc == LIM) ? ARB_FORCE_IF : ARB_LS_RUN;
                    force_if <= cnt_inc == LIM;
                end else begin
                    cnt      <= '0;
                    state    <= ARB_IDLE;
                    force_if <= 1'b0;
                end
                ARB_FORCE_IF: if (if_gnt || !if_req) begin
                    cnt      <= '0;
                    state    <= ARB_IDLE;
                    force_if <= 1'b0;
                end
                default: begin
                    cnt      <= '0;
                    state    <= ARB_IDLE;
                    force_if <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and load/store
//   clk, rst (async high); bus (slave modport): IF/LS request+grant, read returns, RAM drive
//   MEM_ARB_STATS_EN adds stat_if_stall/stat_ls_stall saturating stall counters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_W_DEF,
    parameter int DATA_WIDTH   = DATA_W_DEF,
    parameter int MEM_DEPTH    = MEM_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_if_stall,
    output logic [31:0] stat_ls_stall
`endif
);
    logic                  force_if;
    logic                  ls_in_range;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [1:0]            own_q;
    logic                  err_q;
    // one extra bit so a depth equal to the full address space still compares correctly
    assign ls_in_range   = {1'b0, bus.ls_addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH);
    assign bus.ls_gnt    = !rst && bus.ls_req && !(force_if && bus.if_req);
    assign bus.if_gnt    = !rst && bus.if_req && !bus.ls_gnt;
    assign bus.ram_a     = bus.ls_gnt ? bus.ls_addr : bus.if_gnt ? bus.if_addr : a_q;
    assign bus.ram_din   = bus.ls_wdata;
    assign bus.ram_rw    = bus.ls_gnt && bus.ls_we && ls_in_range;
    assign bus.if_rvalid = own_q == OWN_IF;
    assign bus.ls_rvalid = own_q == OWN_LS;
    assign bus.ls_err    = err_q;
    assign bus.if_rdata  = bus.if_rvalid ? bus.ram_dout : '0;
    assign bus.ls_rdata  = (bus.ls_rvalid && !err_q) ? bus.ram_dout : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            own_q <= OWN_NONE;
            err_q <= 1'b0;
        end else begin
            a_q   <= bus.ram_a;
            own_q <= bus.if_gnt ? OWN_IF : (bus.ls_gnt && !bus.ls_we) ? OWN_LS : OWN_NONE;
            err_q <= bus.ls_gnt && !ls_in_range;
        end
    end
    mem_arb_fairness #(.STARVE_LIMIT(STARVE_LIMIT)) u_fair (
        .clk     (clk),
        .rst     (rst),
        .if_req  (bus.if_req),
        .if_gnt  (bus.if_gnt),
        .ls_gnt  (bus.ls_gnt),
        .force_if(force_if)
    );
`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_if_stall <= '0;
            stat_ls_stall <= '0;
        end else begin
            if (bus.if_req && !bus.if_gnt && stat_if_stall != '1) stat_if_stall <= stat_if_stall + 32'd1;
            if (bus.ls_req && !bus.ls_gnt && stat_ls_stall != '1) stat_ls_stall <= stat_ls_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of the arbiter against a streak-count reference model
module tb_mem_port_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8192;
    localparam int LIMIT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_stall;
    logic [31:0] stat_ls_stall;
`endif
    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_stall(stat_if_stall),
        .stat_ls_stall(stat_ls_stall)
`endif
    );
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    logic [DW-1:0] mem    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = DW'(i) * 32'h9E3779B1;
            shadow[i] = mem[i];
        end
        mem[0] = 32'hE3A00001; shadow[0] = 32'hE3A00001;
        mem[1] = 32'hE2800002; shadow[1] = 32'hE2800002;
        mem[2] = 32'hEA000000; shadow[2] = 32'hEA000000;
    end
    always @(posedge clk) begin
        bus.ram_dout <= (bus.ram_a < AW'(DEPTH)) ? mem[bus.ram_a[12:0]] : 32'hBADBAD00;
        if (bus.ram_rw && bus.ram_a < AW'(DEPTH)) mem[bus.ram_a[12:0]] = bus.ram_din;
    end
    int            streak;
    logic          p_if, p_ls, p_err;
    logic [DW-1:0] p_if_d, p_ls_d;
    logic [AW-1:0] last_a;
    always @(negedge clk) begin : model
        logic          e_if, e_ls, e_rw, ls_ok;
        logic [AW-1:0] e_a;
        if (rst) begin
            chk("rst_if_gnt", bus.if_gnt, 0);
            chk("rst_ls_gnt", bus.ls_gnt, 0);
            chk("rst_ram_rw", bus.ram_rw, 0);
            chk("rst_if_rvalid", bus.if_rvalid, 0);
            chk("rst_ls_rvalid", bus.ls_rvalid, 0);
            chk("rst_ls_err", bus.ls_err, 0);
            streak = 0;
            p_if = 0; p_ls = 0; p_err = 0; p_if_d = 0; p_ls_d = 0;
            last_a = 0;
        end else begin
            ls_ok = bus.ls_addr < AW'(DEPTH);
            e_ls  = bus.ls_req && !(bus.if_req && streak >= LIMIT);
            e_if  = bus.if_req && !e_ls;
            e_rw  = e_ls && bus.ls_we && ls_ok;
            e_a   = e_ls ? bus.ls_addr : e_if ? bus.if_addr : last_a;
            chk("m_if_gnt", bus.if_gnt, e_if);
            chk("m_ls_gnt", bus.ls_gnt, e_ls);
            chk("m_ram_rw", bus.ram_rw, e_rw);
            chk("m_ram_a", bus.ram_a, e_a);
            if (e_rw) chk("m_ram_din", bus.ram_din, bus.ls_wdata);
            chk("m_if_rvalid", bus.if_rvalid, p_if);
            chk("m_ls_rvalid", bus.ls_rvalid, p_ls);
            chk("m_ls_err", bus.ls_err, p_err);
            if (p_if) chk("m_if_rdata", bus.if_rdata, p_if_d);
            if (p_ls) chk("m_ls_rdata", bus.ls_rdata, p_ls_d);
            p_if   = e_if;
            p_if_d = shadow[bus.if_addr[12:0]];
            p_ls   = e_ls && !bus.ls_we;
            p_ls_d = ls_ok ? shadow[bus.ls_addr[12:0]] : '0;
            p_err  = e_ls && !ls_ok;
            if (e_rw) shadow[bus.ls_addr[12:0]] = bus.ls_wdata;
            streak = (bus.if_req && e_ls) ? streak + 1 : 0;
            last_a = e_a;
        end
    end
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic sample;
        @(negedge clk);
    endtask
    logic g_if, g_ls;
    initial begin
        bus.if_req = 1; bus.if_addr = 0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
        repeat (2) @(posedge clk);
        sample;
        chk("reset_no_if_gnt", bus.if_gnt, 0);
        chk("reset_ram_rw", bus.ram_rw, 0);
        chk("reset_if_rvalid", bus.if_rvalid, 0);
        step; rst = 0;
        sample; chk("release_if_gnt", bus.if_gnt, 1);
        step; bus.if_addr = 0;
        sample; chk("fetch0_gnt", bus.if_gnt, 1);
        step; bus.if_addr = 1;
        sample; chk("fetch0_rvalid", bus.if_rvalid, 1); chk("fetch0_data", bus.if_rdata, 32'hE3A00001);
        step; bus.if_addr = 2;
        sample; chk("fetch1_data", bus.if_rdata, 32'hE2800002);
        step; bus.if_req = 0;
        sample; chk("fetch2_rvalid", bus.if_rvalid, 1); chk("fetch2_data", bus.if_rdata, 32'hEA000000);
        step;
        sample; chk("fetch_done", bus.if_rvalid, 0);
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 100; bus.ls_wdata = 32'hDEADBEEF;
        sample; chk("store_gnt", bus.ls_gnt, 1); chk("store_rw", bus.ram_rw, 1); chk("store_a", bus.ram_a, 100);
        step; bus.ls_we = 0;
        sample; chk("store_no_rvalid", bus.ls_rvalid, 0);
        step; bus.ls_req = 0;
        sample;
        chk("load_rvalid", bus.ls_rvalid, 1);
        chk("load_data", bus.ls_rdata, 32'hDEADBEEF);
        chk("load_no_if_rvalid", bus.if_rvalid, 0);
        step; bus.if_req = 1; bus.if_addr = 3; bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 4;
        for (int i = 0; i < 10; i++) begin
            sample;
            chk("starve_if_gnt", bus.if_gnt, (i % 5) == 4);
            chk("starve_ls_gnt", bus.ls_gnt, (i % 5) != 4);
            step;
        end
        bus.if_req = 0; bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 8192; bus.ls_wdata = 32'h1234;
        sample; chk("oor_store_gnt", bus.ls_gnt, 1); chk("oor_store_rw", bus.ram_rw, 0);
        step; bus.ls_we = 0;
        sample; chk("oor_store_err", bus.ls_err, 1); chk("oor_store_no_rv", bus.ls_rvalid, 0); chk("oor_load_rw", bus.ram_rw, 0);
        step; bus.ls_req = 0;
        sample; chk("oor_load_err", bus.ls_err, 1); chk("oor_load_rv", bus.ls_rvalid, 1); chk("oor_load_data", bus.ls_rdata, 0);
        step;
        sample; chk("oor_err_clear", bus.ls_err, 0);
        bus.if_req = 1; bus.if_addr = 5;
        sample; chk("midrst_gnt", bus.if_gnt, 1);
        step; rst = 1; bus.if_req = 0;
        sample; chk("midrst_no_rvalid", bus.if_rvalid, 0);
        step; rst = 0;
        sample; chk("midrst_still_none", bus.if_rvalid, 0);
`ifdef MEM_ARB_STATS_EN
        step; bus.if_req = 1; bus.if_addr = 6; bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 7;
        sample; chk("stat_contest_ls", bus.ls_gnt, 1);
        step; bus.ls_req = 0;
        sample; chk("stat_if_one", stat_if_stall, 1);
        step; bus.if_req = 0; rst = 1;
        sample; chk("stat_if_clear", stat_if_stall, 0);
        step; rst = 0;
`endif
        g_if = 1; g_ls = 1;
        for (int n = 0; n < 3000; n++) begin
            step;
            rst = ($urandom % 250) == 0;
            if (!bus.if_req || g_if) begin
                bus.if_req  = ($urandom % 3) != 0;
                bus.if_addr = $urandom % 64;
            end
            if (!bus.ls_req || g_ls) begin
                bus.ls_req   = ($urandom % 3) != 0;
                bus.ls_we    = $urandom % 2;
                bus.ls_addr  = (($urandom % 8) == 0) ? AW'(DEPTH + $urandom % 16) : AW'($urandom % 64);
                bus.ls_wdata = $urandom;
            end
            sample;
            g_if = bus.if_gnt;
            g_ls = bus.ls_gnt;
        end
        step; rst = 0; bus.if_req = 0; bus.ls_req = 0;
        step;
        sample;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port word-addressed random_access_memory between two requesters.
  - Instruction fetch port (IF): reads only.
  - Load/store port (LS): reads and writes.
- Issues at most one RAM access per cycle.
- Routes the synchronous read data back to the requester that owns it.
- Bounds fetch starvation under sustained load/store traffic.
- Sits between control_unit and the RAM instance, replacing the direct ram_a/ram_rw drive.

Parameters:
- ADDR_WIDTH, 32, word-address width of both ports and RAM.
- DATA_WIDTH, 32, data width.
- MEM_DEPTH, 8192, number of implemented RAM words; accesses at addresses >= MEM_DEPTH are out of range.
- STARVE_LIMIT, 4, maximum consecutive LS grants while IF is requesting before IF is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch word address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid; asserted the cycle after if_gnt.
- if_rdata  out  DATA_WIDTH  fetch data.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_WIDTH  load/store word address.
- ls_wdata  in  DATA_WIDTH  store data.
- ls_gnt  out  1  load/store accepted this cycle (combinational).
- ls_rvalid  out  1  load data valid; asserted the cycle after a load grant.
- ls_rdata  out  DATA_WIDTH  load data.
- ls_err  out  1  one-cycle pulse the cycle after an out-of-range LS grant.
- ram_a  out  ADDR_WIDTH  RAM address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_rw  out  1  RAM write enable.
- ram_dout  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- Reset:
  - if_rvalid, ls_rvalid and ls_err are 0.
  - FSM is in ARB_IDLE; the starvation counter is 0.
  - if_rdata and ls_rdata are 0.
  - ram_rw is 0 while rst is high.
  - Reset mid-operation discards any pending read return; no rvalid follows.
- Grant rules (combinational, same cycle as the request):
  - Only one of if_gnt or ls_gnt is high in any cycle.
  - LS has priority, except in state ARB_FORCE_IF, where IF wins if if_req is high.
  - A lone requester always wins.
- RAM drive:
  - ram_a = winner's address.
  - ram_din = ls_wdata.
  - ram_rw = ls_gnt & ls_we & in-range.
  - With no grant: ram_rw = 0 and ram_a holds its last value.
- Read return:
  - A 2-bit owner register {if, ls} is captured on each read grant.
  - Next cycle, the owner's rvalid = 1 and its rdata = ram_dout. Latency is 1 cycle; reads are fully pipelined, one per cycle.
  - Stores produce no rvalid; the write commits at the grant edge.
  - Back-to-back mixed grants, for example an LS load then an IF fetch, return in grant order on consecutive cycles.
- Out-of-range LS access:
  - Write is suppressed.
  - A load returns ls_rdata = 0 with ls_rvalid = 1 and ls_err = 1.
  - An out-of-range store pulses ls_err only.
  - IF addresses are not range-checked.
- FSM (state changes on clock edge):
  - ARB_IDLE: LS grant while if_req → ARB_LS_RUN, count = 1.
  - ARB_LS_RUN:
    - LS grant while if_req → count++; when count == STARVE_LIMIT → ARB_FORCE_IF.
    - IF grant, or if_req low → ARB_IDLE, count = 0.
  - ARB_FORCE_IF:
    - IF granted → ARB_IDLE, count = 0.
    - If if_req drops, → ARB_IDLE.
- Simultaneous events:
  - if_req and ls_req both high in ARB_IDLE → LS wins.
  - A request arriving in the same cycle as its own rvalid is legal.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_if_stall [31:0] and stat_ls_stall [31:0].
  - Each counts cycles with req high and gnt low for its port.
  - Counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: no ports and no counter logic.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_LS_RUN, ARB_FORCE_IF}.
  - Owner encoding constants OWN_NONE, OWN_IF, OWN_LS.
  - Default width constants.
- Sub-module mem_arb_fairness: holds the FSM and starvation counter, outputs force_if.
- Grant mux and return routing stay in the top module.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles with if_req = 1.
  - Required: no if_gnt; all rvalids 0; ram_rw = 0.
  - After release: if_gnt next cycle.
- Pipelined fetch:
  - Stimulus: IF-only reads at addresses 0,1,2 on consecutive cycles, RAM preloaded with 0xE3A00001, 0xE2800002, 0xEA000000.
  - Required: if_rvalid on cycles 1,2,3 with that data in order.
- Store then load:
  - Stimulus: ls store 0xDEADBEEF to address 100, then ls load address 100.
  - Required: ls_rvalid the cycle after the load grant with ls_rdata = 0xDEADBEEF; no if_rvalid.
- Starvation bound:
  - Stimulus: ls_req and if_req held high continuously, STARVE_LIMIT = 4.
  - Required: grant pattern LS,LS,LS,LS,IF repeating.
- Out-of-range:
  - Stimulus: ls store to address 8192, then load from 8192.
  - Required: ram_rw stays 0; ls_err pulses twice; load returns 0.
- Reset mid-read:
  - Stimulus: assert rst the cycle after an IF read grant.
  - Required: if_rvalid stays 0.
  - Stats build only: stat_if_stall = 1 after one contested cycle, cleared by rst.
